freelist: RTL and testbench

FREELIST -- requirements
Module: freelist

---
 rtl/rename_pkg.sv | 14 +
 rtl/freelist_if.sv | 42 ++++
 rtl/freelist_mem.sv | 42 ++++
 rtl/freelist.sv | 118 +++++++++++
 tb/tb_freelist.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Rename-stage shared definitions: default register-file geometry and
// the free-list depth/pointer widths derived from it.
package rename_pkg;

    localparam int PREG_NUM_D = 64;
    localparam int CREG_NUM_D = 32;

    localparam int FL_DEPTH = PREG_NUM_D - CREG_NUM_D;
    localparam int PW       = $clog2(PREG_NUM_D);
    localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;

    typedef logic [PW-1:0] preg_addr_t;

endpackage

// File: rtl/freelist_if.sv
// Rename <-> free-list handshake bundle. With FREELIST_RECOVER_EN defined,
// the bundle also carries retire_alloc and flush for checkpoint-free recovery.
interface freelist_if import rename_pkg::*; #(
    parameter int PREG_NUM     = PREG_NUM_D,
    parameter int CREG_NUM     = CREG_NUM_D,
    parameter int FETCH_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2
);
    localparam int PW    = $clog2(PREG_NUM);
    localparam int CNT_W = $clog2(PREG_NUM - CREG_NUM) + 1;

    logic [FETCH_WIDTH-1:0]           alloc_req;
    logic                             alloc_en;
    logic                             alloc_ready;
    logic [FETCH_WIDTH-1:0][PW-1:0]   alloc_preg;
    logic [COMMIT_WIDTH-1:0]          free_valid;
    logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg;
    logic [CNT_W-1:0]                 free_count;
`ifdef FREELIST_RECOVER_EN
    logic [COMMIT_WIDTH-1:0]          retire_alloc;
    logic                             flush;

    modport master (
        output alloc_req, alloc_en, free_valid, free_preg, retire_alloc, flush,
        input  alloc_ready, alloc_preg, free_count
    );
    modport slave (
        input  alloc_req, alloc_en, free_valid, free_preg, retire_alloc, flush,
        output alloc_ready, alloc_preg, free_count
    );
`else
    modport master (
        output alloc_req, alloc_en, free_valid, free_preg,
        input  alloc_ready, alloc_preg, free_count
    );
    modport slave (
        input  alloc_req, alloc_en, free_valid, free_preg,
        output alloc_ready, alloc_preg, free_count
    );
`endif

endinterface

// File: rtl/freelist_mem.sv
// Free-list storage: combinational read ports, slot-ordered write ports,
// reset-loaded with the pregs that are not architecturally mapped.
module freelist_mem #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 6,
    parameter int BASE   = 32,
    parameter int RD_N   = 2,
    parameter int WR_N   = 2,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_N-1:0][IDX_W-1:0]   rd_idx,
    output logic [RD_N-1:0][PREG_W-1:0]  rd_data,
    input  logic [WR_N-1:0]              wr_en,
    input  logic [WR_N-1:0][IDX_W-1:0]   wr_idx,
    input  logic [WR_N-1:0][PREG_W-1:0]  wr_data
);

    logic [PREG_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= PREG_W'(BASE + k);
            end
        end else begin
            for (int j = 0; j < WR_N; j++) begin
                if (wr_en[j]) begin
                    mem[wr_idx[j]] <= wr_data[j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RD_N; i++) begin
            rd_data[i] = mem[rd_idx[i]];
        end
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular buffer with wrap-bit pointers.
// Define FREELIST_RECOVER_EN to add commit_head tracking and flush recovery.
module freelist import rename_pkg::*; #(
    parameter int PREG_NUM     = PREG_NUM_D,
    parameter int CREG_NUM     = CREG_NUM_D,
    parameter int FETCH_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    freelist_if.slave  fl
);

    localparam int DEPTH  = PREG_NUM - CREG_NUM;
    localparam int PREG_W = $clog2(PREG_NUM);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;

    logic [PTR_W-1:0] head, tail, cnt;
    logic [PTR_W-1:0] head_next, tail_next, cnt_next;
    logic [PTR_W-1:0] nalloc, nfree, nalloc_fire;
    logic             ready, fire;

    logic [FETCH_WIDTH-1:0][IDX_W-1:0]   rd_idx;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0]  wr_idx;

`ifdef FREELIST_RECOVER_EN
    logic [PTR_W-1:0] commit_head, commit_head_next, nret;
`endif

    // Each requesting slot takes the entry after those claimed by lower slots.
    always_comb begin
        nalloc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_idx[i] = head[IDX_W-1:0] + nalloc[IDX_W-1:0];
            nalloc    = nalloc + PTR_W'(fl.alloc_req[i]);
        end
        nfree = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            wr_idx[j] = tail[IDX_W-1:0] + nfree[IDX_W-1:0];
            nfree     = nfree + PTR_W'(fl.free_valid[j]);
        end
    end

    always_comb begin
`ifdef FREELIST_RECOVER_EN
        ready = (cnt >= nalloc) && !fl.flush;
        nret  = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            nret = nret + PTR_W'(fl.retire_alloc[j]);
        end
        commit_head_next = commit_head + nret;
`else
        ready = (cnt >= nalloc);
`endif
        fire        = fl.alloc_en && ready;
        nalloc_fire = fire ? nalloc : '0;
        head_next   = head + nalloc_fire;
        tail_next   = tail + nfree;
        cnt_next    = cnt + nfree - nalloc_fire;
`ifdef FREELIST_RECOVER_EN
        // Squash rewinds to the oldest non-retired allocation; frees still land.
        if (fl.flush) begin
            head_next = commit_head_next;
            cnt_next  = tail_next - commit_head_next;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= {1'b1, {IDX_W{1'b0}}};
            cnt  <= PTR_W'(DEPTH);
`ifdef FREELIST_RECOVER_EN
            commit_head <= '0;
`endif
        end else begin
            head <= head_next;
            tail <= tail_next;
            cnt  <= cnt_next;
`ifdef FREELIST_RECOVER_EN
            commit_head <= commit_head_next;
`endif
        end
    end

    // Freeing into a buffer with no room for the released pregs is a protocol error.
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef FREELIST_RECOVER_EN
            assert (int'(PTR_W'(tail - commit_head_next)) + int'(nfree) <= DEPTH);
`else
            assert (int'(cnt) - int'(nalloc_fire) + int'(nfree) <= DEPTH);
`endif
        end
    end

    freelist_mem #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W),
        .BASE   (CREG_NUM),
        .RD_N   (FETCH_WIDTH),
        .WR_N   (COMMIT_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (rd_idx),
        .rd_data (fl.alloc_preg),
        .wr_en   (fl.free_valid),
        .wr_idx  (wr_idx),
        .wr_data (fl.free_preg)
    );

    assign fl.alloc_ready = ready;
    assign fl.free_count  = cnt;

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: the driver queues hand-computed expectations
// per cycle; a negedge monitor pops and compares them against the DUT.
module tb_freelist;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freelist_if #(.PREG_NUM(64), .CREG_NUM(32), .FETCH_WIDTH(2), .COMMIT_WIDTH(2)) fl ();

    freelist #(.PREG_NUM(64), .CREG_NUM(32), .FETCH_WIDTH(2), .COMMIT_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl)
    );

    localparam int SEL_CNT = 0, SEL_RDY = 1, SEL_P0 = 2, SEL_P1 = 3;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_v(input string name, input int sel, input int val);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic set_in(input logic [1:0] req, input logic en, input logic [1:0] fv,
                          input int fp0, input int fp1);
        preg_addr_t p0, p1;
        p0 = preg_addr_t'(fp0);
        p1 = preg_addr_t'(fp1);
        fl.alloc_req    = req;
        fl.alloc_en     = en;
        fl.free_valid   = fv;
        fl.free_preg[0] = p0;
        fl.free_preg[1] = p1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                case (e.sel)
                    SEL_CNT: act = int'(fl.free_count);
                    SEL_RDY: act = int'(fl.alloc_ready);
                    SEL_P0:  act = int'(fl.alloc_preg[0]);
                    default: act = int'(fl.alloc_preg[1]);
                endcase
                checks++;
                if (act != e.val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, e.cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1;
        reset = 1'b1;
        set_in(2'b00, 1'b0, 2'b00, 0, 0);
`ifdef FREELIST_RECOVER_EN
        fl.retire_alloc = 2'b00;
        fl.flush        = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        expect_v("reset_count", SEL_CNT, FL_DEPTH);
        expect_v("reset_ready", SEL_RDY, 1);
        tick();

        // Two-slot allocation straight out of reset
        set_in(2'b11, 1'b1, 2'b00, 0, 0);
        expect_v("dual_ready", SEL_RDY, 1);
        expect_v("dual_slot0", SEL_P0, 32);
        expect_v("dual_slot1", SEL_P1, 33);
        tick();
        set_in(2'b00, 1'b0, 2'b00, 0, 0);
        expect_v("dual_count", SEL_CNT, 30);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Only slot 1 requests: it takes the head entry
        set_in(2'b10, 1'b1, 2'b00, 0, 0);
        expect_v("slot1_only_preg", SEL_P1, 32);
        expect_v("slot1_only_count_before", SEL_CNT, 32);
        tick();
        expect_v("slot1_only_count_after", SEL_CNT, 31);

        // Drain 30 more entries down to one left
        for (int j = 0; j < 15; j++) begin
            set_in(2'b11, 1'b1, 2'b00, 0, 0);
            expect_v("drain_slot0", SEL_P0, 33 + 2 * j);
            expect_v("drain_slot1", SEL_P1, 34 + 2 * j);
            tick();
        end

        // One left, two requested: stall; same-cycle free must not bypass
        set_in(2'b11, 1'b1, 2'b01, 5, 0);
        expect_v("short_ready", SEL_RDY, 0);
        expect_v("short_count", SEL_CNT, 1);
        tick();
        set_in(2'b11, 1'b1, 2'b00, 0, 0);
        expect_v("refill_count", SEL_CNT, 2);
        expect_v("refill_ready", SEL_RDY, 1);
        expect_v("refill_slot0", SEL_P0, 63);
        expect_v("refill_slot1", SEL_P1, 5);
        tick();
        set_in(2'b01, 1'b0, 2'b00, 0, 0);
        expect_v("empty_count", SEL_CNT, 0);
        expect_v("empty_ready", SEL_RDY, 0);
        tick();

        // Reset wins over a concurrent allocate and free
        reset = 1'b1;
        set_in(2'b11, 1'b1, 2'b11, 7, 8);
        tick();
        reset = 1'b0;
        set_in(2'b11, 1'b0, 2'b00, 0, 0);
        expect_v("rst_override_count", SEL_CNT, FL_DEPTH);
        expect_v("rst_override_slot0", SEL_P0, 32);
        expect_v("rst_override_slot1", SEL_P1, 33);
        tick();

        // Steady state: every granted preg returns the same cycle, pointers wrap
        for (int k = 0; k < 40; k++) begin
            a0 = 32 + (2 * k) % 32;
            a1 = 32 + (2 * k + 1) % 32;
            set_in(2'b11, 1'b1, 2'b11, a0, a1);
            expect_v("wrap_slot0", SEL_P0, a0);
            expect_v("wrap_slot1", SEL_P1, a1);
            expect_v("wrap_count", SEL_CNT, 32);
            tick();
        end
        set_in(2'b11, 1'b0, 2'b00, 0, 0);
        expect_v("wrap_final_count", SEL_CNT, 32);
        expect_v("wrap_final_slot0", SEL_P0, 48);
        expect_v("wrap_final_slot1", SEL_P1, 49);
        tick();

`ifdef FREELIST_RECOVER_EN
        // Allocate 6 over three cycles; two retire cycles of 2'b11 move commit_head to 4
        reset = 1'b1;
        set_in(2'b00, 1'b0, 2'b00, 0, 0);
        tick();
        reset = 1'b0;
        set_in(2'b11, 1'b1, 2'b00, 0, 0);
        tick();
        fl.retire_alloc = 2'b11;
        tick();
        tick();
        fl.retire_alloc = 2'b00;
        fl.flush        = 1'b1;
        expect_v("flush_ready", SEL_RDY, 0);
        expect_v("flush_count_before", SEL_CNT, 26);
        tick();
        fl.flush = 1'b0;
        set_in(2'b11, 1'b0, 2'b00, 0, 0);
        expect_v("flush_count_after", SEL_CNT, 28);
        expect_v("flush_slot0", SEL_P0, 36);
        expect_v("flush_slot1", SEL_P1, 37);
        tick();
`endif

        set_in(2'b00, 1'b0, 2'b00, 0, 0);
        repeat (3) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
